display_scan_controller: RTL
============================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digits; legal range is 2..8.
REQ-002 Parameter DWELL_CYCLES, default 50000, SHALL set the clocks each digit is driven; minimum is 2.
REQ-003 Parameter GUARD_CYCLES, default 500, SHALL set the all-off clocks between digits; minimum is 1.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port valueIn, input, 4*NUM_DIGITS bits: nibble i is the hex code for digit i, and digit 0 is least significant.
REQ-007 Port loadValid, input, 1 bit: valueIn is offered for load.
REQ-008 Port loadReady, output, 1 bit: the shadow register is empty and can accept a load.
REQ-009 Port blankLeadZeros, input, 1 bit: enables leading-zero suppression.
REQ-010 Port numAct, output, 4 bits: nibble for the shared hex-to-7-segment decoder.
REQ-011 Port digitSel, output, NUM_DIGITS bits: active-low digit enables, at most one bit low at any time.
REQ-012 Port frameDone, output, 1 bit: one-clock pulse at the end of each full scan frame.

Function
REQ-013 A load SHALL be accepted on a clock where loadValid and loadReady are both 1; valueIn is then captured into the shadow register and the shadow is marked full.
REQ-014 loadReady SHALL equal NOT shadow-full, driven from a register with no combinational path from loadValid.
REQ-015 The FSM SHALL have exactly three states: IDLE, SCAN and GUARD.
REQ-016 IDLE: digitSel is all ones and numAct is 0; if the shadow is full, the next clock copies shadow to active, clears shadow-full, and enters SCAN with digit index 0.
REQ-017 SCAN: numAct is active nibble[index].
REQ-018 SCAN: digitSel[index] is 0 unless that digit is suppressed; all other bits are 1.
REQ-019 SCAN SHALL last exactly DWELL_CYCLES clocks, then enter GUARD.
REQ-020 GUARD: digitSel is all ones and numAct holds its last value.
REQ-021 GUARD SHALL last exactly GUARD_CYCLES clocks, then enter SCAN with index = (index+1) mod NUM_DIGITS.
REQ-022 The frame boundary is the last GUARD clock with index = NUM_DIGITS-1; frameDone SHALL be 1 on exactly that clock.
REQ-023 At a frame boundary with shadow full, the shadow SHALL be copied to active and shadow-full cleared, so the next frame shows the new value.
REQ-024 Active contents SHALL change only at a frame boundary or on the IDLE exit, never mid-frame.
REQ-025 An accepted load coinciding with a frame boundary SHALL fill the shadow only; it is transferred at the following boundary.
REQ-026 Suppression: when blankLeadZeros=1, digit i (i>0) is suppressed if active nibbles i..NUM_DIGITS-1 are all 0.
REQ-027 Digit 0 SHALL never be suppressed.
REQ-028 A suppressed digit SHALL keep its full SCAN and GUARD timing so the frame period is constant.
REQ-029 blankLeadZeros SHALL be sampled every clock; a change takes effect on the next SCAN clock.
REQ-030 The dwell/guard counter SHALL be wide enough for max(DWELL_CYCLES, GUARD_CYCLES)-1 and SHALL reload to 0 on every state change.
REQ-031 The FSM SHALL never return to IDLE except through reset.

Reset
REQ-032 While rst=1 at a clock edge: state=IDLE, index=0, counter=0, active=0, shadow=0, shadow-full=0.
REQ-033 While rst=1 the outputs SHALL be: loadReady=0, digitSel all ones, numAct=0, frameDone=0.
REQ-034 loadReady SHALL be 1 on the first clock after rst falls.
REQ-035 Reset asserted mid-SCAN or mid-GUARD SHALL abort the scan within that clock and discard any pending shadow value.

Structure
REQ-036 A shared package display_pkg SHALL hold the FSM state enum, the digit-code width constant (4), and the default parameter values.
REQ-037 The dwell/guard counter SHALL be one sub-module, display_tick_counter, with inputs load and terminal value and output done.
REQ-038 The hex-to-7-segment decoder SHALL remain outside this block; the top level connects numAct to it.

Verification (NUM_DIGITS=4, DWELL_CYCLES=4, GUARD_CYCLES=2)
REQ-039 Scenario: release rst with no load -> digitSel stays 4'b1111, numAct=0, loadReady=1 for 50 clocks.
REQ-040 Scenario: load 16'h1A3F -> digit 0 shows F, then 3, A, 1, each low for 4 clocks separated by 2 all-off clocks; frameDone pulses every 24 clocks.
REQ-041 Scenario: load 16'h0007 with blankLeadZeros=1 -> only digitSel[0] ever goes low, showing 7; frameDone period stays 24.
REQ-042 Scenario: load 16'h1234 then 16'h5678 mid-frame -> loadReady=0 until the boundary, the frame finishes showing 1234, and the next frame shows 5678.
REQ-043 Scenario: loadValid held with 16'h9999 across a frame boundary while the shadow is empty -> accepted at the boundary and displayed one frame later.
REQ-044 Scenario: rst pulsed during GUARD of digit 2 -> next clock is IDLE with digitSel 4'b1111 and loadReady=1 after release; the old value is not redisplayed.

Source files
------------

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared definitions for the multiplexed display scan controller:
//   - scan_state_e : FSM state encoding (IDLE / SCAN / GUARD)
//   - DIGIT_W      : width of one digit code (hex nibble)
//   - DEF_*        : default parameter values for the top level
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int DIGIT_W          = 4;
    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_DWELL_CYCLES = 50000;
    localparam int DEF_GUARD_CYCLES = 500;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_e;

endpackage

// File: rtl/display_tick_counter.sv
// -----------------------------------------------------------------------------
// display_tick_counter
// Dwell/guard timer. Counts up from 0 and stops at the terminal value.
// Ports:
//   clk  - clock (rising edge)
//   rst  - synchronous active-high reset, clears the count
//   load - restart the count at 0 on the next clock
//   term - terminal count (number of clocks in the interval minus one)
//   done - high while the count equals term
// -----------------------------------------------------------------------------
module display_tick_counter
    import display_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign done = (cnt_q == term);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Time-multiplexes NUM_DIGITS hex digits onto one shared 7-segment decoder.
// Each digit is driven for DWELL_CYCLES clocks followed by GUARD_CYCLES
// all-off clocks. New values are double-buffered (shadow -> active) and only
// take effect at a frame boundary so a frame never shows a mix of values.
// Ports:
//   clk            - clock (rising edge)
//   rst            - synchronous active-high reset
//   valueIn        - NUM_DIGITS hex nibbles, digit 0 in the low nibble
//   loadValid      - valueIn offered for load
//   loadReady      - shadow register empty, load will be accepted
//   blankLeadZeros - suppress leading zero digits (digit 0 always shown)
//   numAct         - nibble for the external hex-to-7-segment decoder
//   digitSel       - active-low digit enables, at most one low
//   frameDone      - one-clock pulse on the last clock of each frame
// -----------------------------------------------------------------------------
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] valueIn,
    input  logic                          loadValid,
    output logic                          loadReady,
    input  logic                          blankLeadZeros,
    output logic [DIGIT_W-1:0]            numAct,
    output logic [NUM_DIGITS-1:0]         digitSel,
    output logic                          frameDone
);

    localparam int VAL_W   = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int MAX_CYC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] active_q, active_d;
    logic [VAL_W-1:0] shadow_q, shadow_d;
    logic             full_q, full_d;
    logic             ready_q;
    logic             blank_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_term;
    logic             cnt_done;
    logic             boundary;
    logic             accept;
    logic             xfer;
    logic [DIGIT_W-1:0]    cur_nib;
    logic [NUM_DIGITS-1:0] suppress;
    logic                  zero_run;

    display_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .term (cnt_term),
        .done (cnt_done)
    );

    // Last GUARD clock of the last digit closes the frame.
    assign boundary = (state_q == ST_GUARD) && cnt_done && (idx_q == LAST_IDX);
    // ready_q mirrors "shadow empty" but is registered, so accept never
    // depends combinationally on loadValid through loadReady.
    assign loadReady = ready_q && !rst;
    assign accept    = loadValid && loadReady;
    assign xfer      = full_q && ((state_q == ST_IDLE) || boundary);
    assign cur_nib   = active_q[int'(idx_q)*DIGIT_W +: DIGIT_W];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        cnt_term = '0;
        case (state_q)
            ST_IDLE: begin
                if (full_q) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                cnt_term = CNT_W'(DWELL_CYCLES - 1);
                if (cnt_done) state_d = ST_GUARD;
            end
            ST_GUARD: begin
                cnt_term = CNT_W'(GUARD_CYCLES - 1);
                if (cnt_done) state_d = ST_SCAN;
            end
            default: state_d = ST_IDLE;
        endcase
        cnt_load = (state_d != state_q);
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        idx_d    = idx_q;
        active_d = xfer ? shadow_q : active_q;
        shadow_d = accept ? valueIn : shadow_q;
        full_d   = full_q;
        if (xfer) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d = 1'b1;
        end
        if (state_q == ST_IDLE) begin
            idx_d = '0;
        end else if ((state_q == ST_GUARD) && cnt_done) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            active_q <= '0;
            shadow_q <= '0;
            full_q   <= 1'b0;
            ready_q  <= 1'b0;
            blank_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            full_q   <= full_d;
            ready_q  <= !full_d;
            blank_q  <= blankLeadZeros;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        // A digit is blank when it and every more significant digit are zero.
        zero_run = blank_q;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run && (active_q[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(0));
            suppress[i] = zero_run;
        end

        digitSel  = '1;
        numAct    = '0;
        frameDone = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_SCAN: begin
                    numAct = cur_nib;
                    if (!suppress[idx_q]) digitSel[idx_q] = 1'b0;
                end
                ST_GUARD: begin
                    // Index is unchanged in GUARD, so this holds the last SCAN nibble.
                    numAct    = cur_nib;
                    frameDone = boundary;
                end
                default: ;
            endcase
        end
    end

endmodule
